// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned AW_DEF = 4;
    localparam int unsigned DW_DEF = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the requester that did not win last time wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  req_id_t last,
    output req_id_t winner,
    output logic    any
);

    // Pick the sole requester, or alternate against last on contention
    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of a small async-read, sync-write data memory.
// Optional DMEM_ARB_LOCK_EN adds lock0/lock1 so a requester can hold the memory across
// consecutive rounds (atomic read-modify-write).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_di,
    input  logic [DW-1:0] mem_do,
    output logic          busy
);

    state_t        state;
    req_id_t       last;
    req_id_t       id;
    req_id_t       pick;
    req_id_t       winner;
    logic          any;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .winner (pick),
        .any    (any)
    );

`ifdef DMEM_ARB_LOCK_EN
    logic    lock_on;
    req_id_t lock_own;
    logic    own_hold;

    // Lock owner keeps winning while it holds both req and lock
    always_comb begin
        own_hold = lock_on && (lock_own ? (req1 && lock1) : (req0 && lock0));
        winner   = own_hold ? lock_own : pick;
    end

    // Lock state is re-evaluated at every arbitration edge from the winner's lock input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_on  <= 1'b0;
            lock_own <= 1'b0;
        end else if (state == IDLE && any) begin
            lock_on  <= winner ? lock1 : lock0;
            lock_own <= winner;
        end
    end
`else
    // Pure round-robin
    always_comb begin
        winner = pick;
    end
`endif

    // Mux the winning requester's command fields
    always_comb begin
        sel_we    = winner ? we1    : we0;
        sel_addr  = winner ? addr1  : addr0;
        sel_wdata = winner ? wdata1 : wdata0;
    end

    // Memory drive: write only in ACCESS and never while reset is asserted
    always_comb begin
        mem_we   = rst_n && (state == ACCESS) && cmd_we;
        mem_addr = cmd_addr;
        mem_di   = cmd_wdata;
    end

    // FSM, command latch and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            id        <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            busy      <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            busy    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        cmd_we    <= sel_we;
                        cmd_addr  <= sel_addr;
                        cmd_wdata <= sel_wdata;
                        id        <= winner;
                        last      <= winner;
                        busy      <= 1'b1;
                        if (winner) begin
                            gnt1 <= 1'b1;
                        end else begin
                            gnt0 <= 1'b1;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!cmd_we) begin
                        if (id) begin
                            rdata1  <= mem_do;
                            rvalid1 <= 1'b1;
                        end else begin
                            rdata0  <= mem_do;
                            rvalid0 <= 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural memory and arbitration model.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, we0, req1, we1, lock0, lock1;
    logic [3:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
    logic [3:0] rdata0, rdata1, mem_addr, mem_di, mem_do;

    logic [3:0] mem     [16];
    logic [3:0] ref_mem [16];

    int n_chk  = 0;
    int n_fail = 0;
    bit sb_en  = 1'b0;
    int cyc    = 0;

    // reference model state
    int         last_win;
    int         lk_on, lk_own;
    int         rq_p [2];
    int         lkp  [2];
    int         gnt_p;
    int         pend [2];
    logic [3:0] hold [2];
    logic [3:0] exp_q0 [$];
    logic [3:0] exp_q1 [$];
    int         gseq [$];
    int         gcyc [$];
    logic       cur_we    [2];
    logic [3:0] cur_addr  [2];
    logic [3:0] cur_wdata [2];

    dmem_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .we0     (we0),
        .addr0   (addr0),
        .wdata0  (wdata0),
        .gnt0    (gnt0),
        .rvalid0 (rvalid0),
        .rdata0  (rdata0),
        .req1    (req1),
        .we1     (we1),
        .addr1   (addr1),
        .wdata1  (wdata1),
        .gnt1    (gnt1),
        .rvalid1 (rvalid1),
        .rdata1  (rdata1),
`ifdef DMEM_ARB_LOCK_EN
        .lock0   (lock0),
        .lock1   (lock1),
`endif
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_di  (mem_di),
        .mem_do  (mem_do),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 16x4 data memory: async read, sync write
    assign mem_do = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_di;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT responses against the reference model every cycle
    always @(negedge clk) begin
        int w, ew;
        logic rv;
        logic [3:0] rd, e;
        if (sb_en) begin
            for (int k = 0; k < 2; k++) begin
                rv = (k == 1) ? rvalid1 : rvalid0;
                rd = (k == 1) ? rdata1  : rdata0;
                if (pend[k] != 0) begin
                    chk("rvalid", int'(rv), 1);
                    e = hold[k];
                    if (k == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
                    if (k == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
                    chk("rdata", int'(rd), int'(e));
                    hold[k] = e;
                end else begin
                    chk("rvalid_spurious", int'(rv), 0);
                    chk("rdata_hold", int'(rd), int'(hold[k]));
                end
                pend[k] = 0;
            end
            if (gnt0 || gnt1) begin
                w = gnt1 ? 1 : 0;
                chk("gnt_onehot", int'(gnt0 && gnt1), 0);
                chk("gnt_after_gnt", gnt_p, 0);
                if (lk_on != 0 && rq_p[lk_own] != 0 && lkp[lk_own] != 0) ew = lk_own;
                else if (rq_p[0] != 0 && rq_p[1] != 0) ew = 1 - last_win;
                else ew = (rq_p[1] != 0) ? 1 : 0;
                chk("gnt_id", w, ew);
                chk("busy_access", int'(busy), 1);
                chk("mem_we", int'(mem_we), int'(cur_we[w]));
                chk("mem_addr", int'(mem_addr), int'(cur_addr[w]));
                if (cur_we[w]) begin
                    chk("mem_di", int'(mem_di), int'(cur_wdata[w]));
                    ref_mem[cur_addr[w]] = cur_wdata[w];
                end else begin
                    if (w == 0) exp_q0.push_back(ref_mem[cur_addr[w]]);
                    else exp_q1.push_back(ref_mem[cur_addr[w]]);
                    pend[w] = 1;
                end
                last_win = w;
                lk_on    = lkp[w];
                lk_own   = w;
                gseq.push_back(w);
                gcyc.push_back(cyc);
            end else begin
                chk("busy_idle", int'(busy), 0);
                chk("mem_we_idle", int'(mem_we), 0);
                if (gnt_p == 0 && (rq_p[0] != 0 || rq_p[1] != 0)) chk("gnt_missing", 0, 1);
            end
        end
        rq_p[0] = int'(req0);
        rq_p[1] = int'(req1);
        lkp[0]  = int'(lock0);
        lkp[1]  = int'(lock1);
        gnt_p   = int'(gnt0 || gnt1);
    end

    task automatic set_req(input int k, input logic r, input logic we, input logic [3:0] a,
                           input logic [3:0] d, input logic lk);
        if (k == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d; lock0 = lk;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d; lock1 = lk;
        end
        cur_we[k]    = we;
        cur_addr[k]  = a;
        cur_wdata[k] = d;
    endtask

    // Present one command, hold until granted, then release (or keep req for a follow-on)
    task automatic issue(input int k, input logic we, input logic [3:0] a, input logic [3:0] d,
                         input logic lk, input bit keep);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        set_req(k, 1'b1, we, a, d, lk);
        while (!got && n < 40) begin
            @(negedge clk);
            if ((k == 1) ? gnt1 : gnt0) got = 1'b1;
            n++;
        end
        if (!got) chk("gnt_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) set_req(k, 1'b0, we, a, d, 1'b0);
    endtask

    task automatic do_reset(input int ncyc);
        sb_en = 1'b0;
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        set_req(1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        repeat (ncyc) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_ctrl", int'({gnt0, gnt1, rvalid0, rvalid1, busy, mem_we}), 0);
            chk("rst_rdata", int'({rdata0, rdata1}), 0);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        last_win = 1;
        lk_on    = 0;
        lk_own   = 0;
        pend[0]  = 0;
        pend[1]  = 0;
        hold[0]  = 4'h0;
        hold[1]  = 4'h0;
        exp_q0.delete();
        exp_q1.delete();
        sb_en = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] old7;
        int n;
        bit got;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 4'h0;
            ref_mem[i] = 4'h0;
        end
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        set_req(1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

        // reset then idle
        do_reset(2);
        idle(2);

        // single write then read on requester 0
        issue(0, 1'b1, 4'd5, 4'hA, 1'b0, 1'b0);
        issue(0, 1'b0, 4'd5, 4'h0, 1'b0, 1'b0);
        idle(3);
        chk("t2_mem5", int'(mem[5]), 'hA);

        // contention after reset: alternating grants, one every two cycles
        do_reset(1);
        gseq.delete();
        gcyc.delete();
        fork
            for (int i = 0; i < 4; i++) issue(0, 1'b0, 4'd2, 4'h0, 1'b0, i < 3);
            for (int i = 0; i < 4; i++) issue(1, 1'b0, 4'd3, 4'h0, 1'b0, i < 3);
        join
        idle(3);
        chk("t3_count", gseq.size(), 8);
        for (int i = 0; i < gseq.size(); i++) begin
            chk("t3_order", gseq[i], i % 2);
            if (i > 0) chk("t3_spacing", gcyc[i] - gcyc[i-1], 2);
        end

        // randomized traffic from both requesters
        fork
            for (int i = 0; i < 30; i++) begin
                idle($urandom_range(0, 3));
                issue(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom), 1'b0, 1'b0);
            end
            for (int i = 0; i < 30; i++) begin
                idle($urandom_range(0, 3));
                issue(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom), 1'b0, 1'b0);
            end
        join
        idle(4);

        // reset asserted during the ACCESS cycle aborts the write
        sb_en = 1'b0;
        old7  = ref_mem[7];
        set_req(1, 1'b1, 1'b1, 4'd7, old7 ^ 4'hF, 1'b0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            if (gnt1) got = 1'b1;
            n++;
        end
        chk("t4_gnt1", int'(got), 1);
        rst_n = 1'b0;
        #1;
        chk("t4_mem_we", int'(mem_we), 0);
        @(posedge clk);
        #1;
        set_req(1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        chk("t4_mem7", int'(mem[7]), int'(old7));
        chk("t4_busy", int'(busy), 0);
        chk("t4_gnt1_clear", int'(gnt1), 0);
        do_reset(2);

        // write on requester 1 must not pulse rvalid nor disturb rdata
        issue(1, 1'b0, 4'd7, 4'h0, 1'b0, 1'b0);
        issue(1, 1'b1, 4'd0, 4'h9, 1'b0, 1'b0);
        idle(4);
        chk("t6_rdata1", int'(rdata1), int'(old7));
        chk("t6_mem0", int'(mem[0]), 'h9);

`ifdef DMEM_ARB_LOCK_EN
        // lock: requester 0 keeps three rounds, loses the fourth once lock drops
        do_reset(1);
        gseq.delete();
        gcyc.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) issue(0, 1'b0, 4'd1, 4'h0, 1'b1, 1'b1);
                issue(0, 1'b0, 4'd1, 4'h0, 1'b0, 1'b0);
            end
            issue(1, 1'b0, 4'd2, 4'h0, 1'b0, 1'b0);
        join
        idle(3);
        chk("t5_count", gseq.size(), 5);
        if (gseq.size() == 5) begin
            chk("t5_g0", gseq[0], 0);
            chk("t5_g1", gseq[1], 0);
            chk("t5_g2", gseq[2], 0);
            chk("t5_g3", gseq[3], 1);
            chk("t5_g4", gseq[4], 0);
        end
`endif

        idle(4);
        chk("drain_q0", exp_q0.size(), 0);
        chk("drain_q1", exp_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
